// File: rtl/config_tree_adder_pkg.sv
// Shared sideband type and sizing helpers for the pipelined configurable tree adder.
package config_tree_adder_pkg;

    typedef struct packed {
        logic valid;
        logic halved;
        logic last;
    } sideband_t;

    // Width of the {hi,lo} word produced by reduction layer k.
    function automatic int layer_width(input int p, input int k);
        return p + 32'sd2 * (k + 32'sd1);
    endfunction

    function automatic int pipe_latency(input int layers, input int pipe_every);
        return (layers / pipe_every) + 32'sd1;
    endfunction

endpackage

// File: rtl/config_tree_adder_stage.sv
// One reduction layer: pairwise adds on split hi/lo lanes, optionally
// followed by a stall-able pipeline register carrying the beat sideband.
module config_tree_adder_stage
    import config_tree_adder_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int W_IN = 8,
    parameter bit REG  = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [N_IN*W_IN-1:0]          data_i,
    input  sideband_t                     sb_i,
    output logic [(N_IN/2)*(W_IN+2)-1:0]  data_o,
    output sideband_t                     sb_o
);

    localparam int N_OUT = N_IN / 2;
    localparam int W_OUT = W_IN + 2;
    localparam int H_IN  = W_IN / 2;
    localparam int H_OUT = H_IN + 1;

    logic [N_OUT*W_OUT-1:0] sum_s;
    logic [W_IN-1:0]        a_s;
    logic [W_IN-1:0]        b_s;

    // Pairwise add; a halved beat keeps its two lanes carry-isolated.
    always_comb begin
        sum_s = '0;
        a_s   = '0;
        b_s   = '0;
        for (int j = 0; j < N_OUT; j++) begin
            a_s = data_i[(2*j)*W_IN +: W_IN];
            b_s = data_i[(2*j+1)*W_IN +: W_IN];
            if (sb_i.halved) begin
                sum_s[j*W_OUT +: W_OUT] = {
                    H_OUT'($signed(a_s[W_IN-1:H_IN])) + H_OUT'($signed(b_s[W_IN-1:H_IN])),
                    H_OUT'($signed(a_s[H_IN-1:0]))    + H_OUT'($signed(b_s[H_IN-1:0]))
                };
            end else begin
                sum_s[j*W_OUT +: W_OUT] = W_OUT'($signed(a_s)) + W_OUT'($signed(b_s));
            end
        end
    end

    if (REG) begin : g_reg
        // Stage register; holds its beat while the output is stalled.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                data_o <= '0;
                sb_o   <= '0;
            end else if (en_i) begin
                data_o <= sum_s;
                sb_o   <= sb_i;
            end
        end
    end else begin : g_comb
        logic unused_s;
        assign unused_s = ^{clk_i, rst_i, en_i};
        assign data_o   = sum_s;
        assign sb_o     = sb_i;
    end

endmodule

// File: rtl/config_pipelined_tree_adder.sv
// Pipelined, stall-able configurable tree adder (full / halved precision per beat).
// Define CONFIG_TREE_ADDER_ACC_EN to accumulate packets (in_last_i) at the output stage.
module config_pipelined_tree_adder
    import config_tree_adder_pkg::*;
#(
    parameter int INPUTS_AMOUNT = 16,
    parameter int P             = 8,
    parameter int OUT_W         = 32,
    parameter int PIPE_EVERY    = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [P-1:0]     inputs_i [INPUTS_AMOUNT],
    input  logic             halved_precision_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_o
`ifdef CONFIG_TREE_ADDER_ACC_EN
    ,
    input  logic             in_last_i
`endif
);

    localparam int LAYERS = $clog2(INPUTS_AMOUNT);
    localparam int WL     = layer_width(P, LAYERS - 1);
    localparam int HL     = WL / 2;

    if (INPUTS_AMOUNT < 2 || (INPUTS_AMOUNT & (INPUTS_AMOUNT - 1)) != 0) begin : g_chk_inputs
        $fatal(1, "config_pipelined_tree_adder: INPUTS_AMOUNT must be a power of 2 >= 2");
    end
    if ((P % 2) != 0) begin : g_chk_p
        $fatal(1, "config_pipelined_tree_adder: P must be even");
    end
    if (OUT_W < P + 2 * LAYERS) begin : g_chk_out_w
        $fatal(1, "config_pipelined_tree_adder: OUT_W must be >= P+2*LAYERS");
    end
    if (PIPE_EVERY < 1 || PIPE_EVERY > LAYERS) begin : g_chk_pipe
        $fatal(1, "config_pipelined_tree_adder: PIPE_EVERY must be in 1..LAYERS");
    end

    logic                       adv_s;
    logic [INPUTS_AMOUNT*P-1:0] src_data_s;
    sideband_t                  src_sb_s;
    logic [WL-1:0]              fin_data_s;
    sideband_t                  fin_sb_s;
    logic [OUT_W-1:0]           result_s;
    logic                       out_valid_r;
    logic [OUT_W-1:0]           out_data_r;

    // One global advance: everything moves unless a result sits unaccepted.
    assign adv_s       = ~out_valid_r | out_ready_i;
    assign in_ready_o  = adv_s;
    assign out_valid_o = out_valid_r;
    assign out_o       = out_data_r;

    // Flatten operands and attach the beat sideband.
    always_comb begin
        src_data_s = '0;
        for (int i = 0; i < INPUTS_AMOUNT; i++) begin
            src_data_s[i*P +: P] = inputs_i[i];
        end
        src_sb_s.valid  = in_valid_i;
        src_sb_s.halved = halved_precision_i;
`ifdef CONFIG_TREE_ADDER_ACC_EN
        src_sb_s.last   = in_last_i;
`else
        src_sb_s.last   = 1'b0;
`endif
    end

    for (genvar k = 0; k < LAYERS; k++) begin : g_layer
        localparam int W_IN = (k == 0) ? P : layer_width(P, k - 1);
        localparam int N_IN = INPUTS_AMOUNT >> k;
        localparam bit REG  = (((k + 1) % PIPE_EVERY) == 0);

        logic [N_IN*W_IN-1:0]         lyr_in_data_s;
        sideband_t                    lyr_in_sb_s;
        logic [(N_IN/2)*(W_IN+2)-1:0] lyr_out_data_s;
        sideband_t                    lyr_out_sb_s;

        if (k == 0) begin : g_src
            assign lyr_in_data_s = src_data_s;
            assign lyr_in_sb_s   = src_sb_s;
        end else begin : g_src
            assign lyr_in_data_s = g_layer[k-1].lyr_out_data_s;
            assign lyr_in_sb_s   = g_layer[k-1].lyr_out_sb_s;
        end

        config_tree_adder_stage #(
            .N_IN (N_IN),
            .W_IN (W_IN),
            .REG  (REG)
        ) u_stage (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (adv_s),
            .data_i (lyr_in_data_s),
            .sb_i   (lyr_in_sb_s),
            .data_o (lyr_out_data_s),
            .sb_o   (lyr_out_sb_s)
        );
    end

    assign fin_data_s = g_layer[LAYERS-1].lyr_out_data_s;
    assign fin_sb_s   = g_layer[LAYERS-1].lyr_out_sb_s;

    // Final merge: halved beats fold their two lanes together here.
    always_comb begin
        if (fin_sb_s.halved) begin
            result_s = OUT_W'($signed(fin_data_s[WL-1:HL])) + OUT_W'($signed(fin_data_s[HL-1:0]));
        end else begin
            result_s = OUT_W'($signed(fin_data_s));
        end
    end

`ifdef CONFIG_TREE_ADDER_ACC_EN
    logic [OUT_W-1:0] acc_r;
    logic             first_r;
    logic [OUT_W-1:0] acc_next_s;

    // Running packet total; the first beat of a packet starts from zero.
    always_comb begin
        if (first_r) begin
            acc_next_s = result_s;
        end else begin
            acc_next_s = acc_r + result_s;
        end
    end

    // Output/accumulate register: only a packet's last beat is presented.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            acc_r       <= '0;
            first_r     <= 1'b1;
        end else if (adv_s) begin
            if (fin_sb_s.valid) begin
                if (fin_sb_s.last) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= acc_next_s;
                    acc_r       <= '0;
                    first_r     <= 1'b1;
                end else begin
                    out_valid_r <= 1'b0;
                    acc_r       <= acc_next_s;
                    first_r     <= 1'b0;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = fin_sb_s.last;

    // Output register; data only updates on a real beat so bubbles keep out_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (adv_s) begin
            out_valid_r <= fin_sb_s.valid;
            if (fin_sb_s.valid) begin
                out_data_r <= result_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_config_pipelined_tree_adder.sv
// Self-checking bench for config_pipelined_tree_adder; random and directed beats
// checked against a sum-of-operands reference model (packet totals with CONFIG_TREE_ADDER_ACC_EN).
module tb_config_pipelined_tree_adder;

`ifdef CONFIG_TREE_ADDER_ACC_EN
    localparam int IA = 16;
`else
    localparam int IA = 4;
`endif
    localparam int P          = 8;
    localparam int OUT_W      = 32;
    localparam int PIPE_EVERY = 1;
    localparam int LAT        = $clog2(IA) / PIPE_EVERY + 1;

    logic             clk;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [P-1:0]     inputs_i [IA];
    logic             halved_precision_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [OUT_W-1:0] out_o;
`ifdef CONFIG_TREE_ADDER_ACC_EN
    logic             in_last_i;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [OUT_W-1:0] exp_q [$];
    logic [OUT_W-1:0] got_q [$];
    logic [OUT_W-1:0] acc_m;

    config_pipelined_tree_adder #(
        .INPUTS_AMOUNT (IA),
        .P             (P),
        .OUT_W         (OUT_W),
        .PIPE_EVERY    (PIPE_EVERY)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .inputs_i           (inputs_i),
        .halved_precision_i (halved_precision_i),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_o              (out_o)
`ifdef CONFIG_TREE_ADDER_ACC_EN
        ,
        .in_last_i          (in_last_i)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed sum of operands (or of all signed half-operands).
    function automatic logic [OUT_W-1:0] ref_sum(input logic [P-1:0] ops [IA], input logic halved);
        int total;
        logic signed [P-1:0]   f;
        logic signed [P/2-1:0] h;
        logic signed [P/2-1:0] l;
        total = 0;
        foreach (ops[i]) begin
            if (halved) begin
                h = ops[i][P-1:P/2];
                l = ops[i][P/2-1:0];
                total += int'(h) + int'(l);
            end else begin
                f = ops[i];
                total += int'(f);
            end
        end
        return OUT_W'(total);
    endfunction

    // Capture accepted beats (as expected results) and delivered results mid-cycle.
    always @(negedge clk) begin
        if (rst_i) begin
            acc_m = '0;
        end else begin
            if (in_valid_i && in_ready_o) begin
`ifdef CONFIG_TREE_ADDER_ACC_EN
                acc_m = acc_m + ref_sum(inputs_i, halved_precision_i);
                if (in_last_i) begin
                    exp_q.push_back(acc_m);
                    acc_m = '0;
                end
`else
                exp_q.push_back(ref_sum(inputs_i, halved_precision_i));
`endif
            end
            if (out_valid_o && out_ready_i) got_q.push_back(out_o);
        end
    end

    task automatic rand_ops();
        foreach (inputs_i[i]) inputs_i[i] = P'($urandom);
    endtask

    task automatic fill_ops(input logic [P-1:0] v);
        foreach (inputs_i[i]) inputs_i[i] = v;
    endtask

    task automatic drain();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (LAT + 4) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        halved_precision_i = 1'b0;
        out_ready_i = 1'b1;
`ifdef CONFIG_TREE_ADDER_ACC_EN
        in_last_i = 1'b1;
`endif
        fill_ops('0);
        repeat (3) @(posedge clk);
        #2 rst_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
        n_vec++;
        if (out_o !== '0) begin n_err++; $display("FAIL reset_out: got %h want 0", out_o); end
        n_vec++;
        if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready_o); end
    endtask

`ifndef CONFIG_TREE_ADDER_ACC_EN
    task automatic test_directed();
        logic [P-1:0]     vals [4] = '{8'h7F, 8'h80, 8'h7F, 8'h88};
        logic             hv   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [OUT_W-1:0] expv [4] = '{32'h0000_01FC, 32'hFFFF_FE00, 32'h0000_0018, 32'hFFFF_FFC0};
        int  lat;
        logic seen;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #2;
            in_valid_i = 1'b1;
            halved_precision_i = hv[t];
            fill_ops(vals[t]);
            out_ready_i = 1'b1;
            lat = 0;
            seen = 1'b0;
            for (int c = 1; c <= LAT + 4 && !seen; c++) begin
                @(posedge clk); #2;
                in_valid_i = 1'b0;
                @(negedge clk);
                if (out_valid_o) begin seen = 1'b1; lat = c; end
            end
            n_vec++;
            if (!seen || lat != LAT) begin
                n_err++; $display("FAIL dir_latency[%0d]: got %0d cycles (seen=%b) want %0d", t, lat, seen, LAT);
            end
            n_vec++;
            if (out_o !== expv[t]) begin
                n_err++; $display("FAIL dir_value[%0d]: got %h want %h", t, out_o, expv[t]);
            end
        end
        @(posedge clk); #2;
        exp_q.delete();
        got_q.delete();
    endtask
`endif

    task automatic test_alternating();
        logic want_v;
        @(posedge clk); #2;
        out_ready_i = 1'b1;
        for (int c = 0; c < LAT + 10; c++) begin
            if (c < 8) begin
                in_valid_i = 1'b1;
                halved_precision_i = 1'(c % 2);
                rand_ops();
            end else begin
                in_valid_i = 1'b0;
            end
            @(negedge clk);
            want_v = (c >= LAT && c < LAT + 8);
            n_vec++;
            if (out_valid_o !== want_v) begin
                n_err++; $display("FAIL alt_valid[%0d]: got %b want %b", c, out_valid_o, want_v);
            end
            @(posedge clk); #2;
        end
        drain();
        n_vec++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            n_err++; $display("FAIL alt_count: got %0d results want %0d", got_q.size(), 8);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL alt_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        int sent;
        int cyc;
        logic need_new;
        logic have_hold;
        logic exp_rdy;
        logic [OUT_W-1:0] hold_v;
        @(posedge clk); #2;
        sent = 0; cyc = 0; need_new = 1'b1; have_hold = 1'b0; hold_v = '0;
        while (sent < 6 && cyc < 50) begin
            if (need_new) begin
                in_valid_i = 1'b1;
                halved_precision_i = 1'($urandom_range(0, 1));
                rand_ops();
            end
            out_ready_i = !(cyc >= 4 && cyc < 8);
            @(negedge clk);
            exp_rdy = !out_valid_o || out_ready_i;
            n_vec++;
            if (in_ready_o !== exp_rdy) begin
                n_err++; $display("FAIL bp_ready[%0d]: got %b want %b", cyc, in_ready_o, exp_rdy);
            end
            if (have_hold) begin
                n_vec++;
                if (out_valid_o !== 1'b1 || out_o !== hold_v) begin
                    n_err++; $display("FAIL bp_hold[%0d]: got valid=%b out=%h want valid=1 out=%h", cyc, out_valid_o, out_o, hold_v);
                end
            end
            have_hold = out_valid_o && !out_ready_i;
            hold_v = out_o;
            need_new = in_valid_i && in_ready_o;
            if (need_new) sent++;
            @(posedge clk); #2;
            cyc++;
        end
        n_vec++;
        if (sent != 6) begin n_err++; $display("FAIL bp_sent: got %0d beats accepted want 6", sent); end
        drain();
        n_vec++;
        if (got_q.size() != 6 || exp_q.size() != 6) begin
            n_err++; $display("FAIL bp_count: got %0d results want 6", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL bp_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        logic pending;
        logic exp_rdy;
        @(posedge clk); #2;
        pending = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (!pending) begin
                in_valid_i = ($urandom_range(0, 9) < 7);
                halved_precision_i = 1'($urandom_range(0, 1));
                rand_ops();
`ifdef CONFIG_TREE_ADDER_ACC_EN
                in_last_i = ($urandom_range(0, 2) == 0);
`endif
            end
            out_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_rdy = !out_valid_o || out_ready_i;
            n_vec++;
            if (in_ready_o !== exp_rdy) begin
                n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready_o, exp_rdy);
            end
            pending = in_valid_i && !in_ready_o;
            @(posedge clk); #2;
        end
        out_ready_i = 1'b1;
        in_valid_i = 1'b1;
        rand_ops();
`ifdef CONFIG_TREE_ADDER_ACC_EN
        in_last_i = 1'b1;
`endif
        @(posedge clk); #2;
        drain();
        n_vec++;
        if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin
            n_err++; $display("FAIL rand_count: got %0d results want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL rand_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_flight();
        @(posedge clk); #2;
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            halved_precision_i = 1'(i % 2);
            fill_ops(8'h11);
            @(posedge clk); #2;
        end
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk); #2;
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid_o !== 1'b0 || out_o !== '0) begin
            n_err++; $display("FAIL flush_now: got valid=%b out=%h want valid=0 out=0", out_valid_o, out_o);
        end
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid_o !== 1'b0) begin
                n_err++; $display("FAIL flush_stale[%0d]: got valid=%b want 0", c, out_valid_o);
            end
        end
        n_vec++;
        if (got_q.size() != 0) begin n_err++; $display("FAIL flush_results: got %0d results want 0", got_q.size()); end
        @(posedge clk); #2;
        exp_q.delete();
        got_q.delete();
    endtask

`ifdef CONFIG_TREE_ADDER_ACC_EN
    task automatic test_acc();
        @(posedge clk); #2;
        out_ready_i = 1'b1;
        halved_precision_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid_i = 1'b1;
            fill_ops(8'h01);
            in_last_i = (b == 2);
            @(posedge clk); #2;
        end
        drain();
        n_vec++;
        if (got_q.size() != 1) begin n_err++; $display("FAIL acc_count1: got %0d results want 1", got_q.size()); end
        n_vec++;
        if (got_q.size() < 1 || got_q[0] !== 32'd48) begin
            n_err++; $display("FAIL acc_total1: got %h want %h", (got_q.size() > 0) ? got_q[0] : 32'hX, 32'd48);
        end
        got_q.delete();
        exp_q.delete();
        in_valid_i = 1'b1;
        fill_ops(8'hFF);
        in_last_i = 1'b1;
        @(posedge clk); #2;
        drain();
        n_vec++;
        if (got_q.size() != 1) begin n_err++; $display("FAIL acc_count2: got %0d results want 1", got_q.size()); end
        n_vec++;
        if (got_q.size() < 1 || got_q[0] !== 32'hFFFF_FFF0) begin
            n_err++; $display("FAIL acc_total2: got %h want %h", (got_q.size() > 0) ? got_q[0] : 32'hX, 32'hFFFF_FFF0);
        end
        got_q.delete();
        exp_q.delete();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifndef CONFIG_TREE_ADDER_ACC_EN
        test_directed();
`endif
        test_alternating();
        test_backpressure();
        test_random();
        test_reset_flight();
`ifdef CONFIG_TREE_ADDER_ACC_EN
        test_acc();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
